// File: rtl/enemy_move.sv
// Per-enemy movement and life-cycle controller: steps the position once per frame,
// backs off or re-heads on wall/bomb/bound contact, and runs a timed death sequence.
module enemy_move #(
  parameter int         INITIAL_X    = 64,
  parameter int         INITIAL_Y    = 64,
  parameter int         SPEED        = 2,
  parameter int         X_MIN        = 32,
  parameter int         X_MAX        = 576,
  parameter int         Y_MIN        = 32,
  parameter int         Y_MAX        = 416,
  parameter int         DEATH_FRAMES = 30,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        wall_collision,
  input  logic        bomb_collision,
  input  logic        explosion_hit,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  direction,
  output logic        visible,
  output logic        dying,
  output logic        dead_pulse
);

  typedef enum logic [1:0] {IDLE, MOVE, DYING, DEAD} state_t;

  localparam int         CNT_W     = $clog2(DEATH_FRAMES + 1);
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  state_t           state, state_nx;
  logic [10:0]      prev_x, prev_y, x_nx, y_nx, prev_x_nx, prev_y_nx;
  logic [1:0]       dir_nx, new_dir;
  logic [CNT_W-1:0] death_cnt, cnt_nx;
  logic [7:0]       lfsr;
  logic             wall_hit, bomb_hit, expl_hit;
  logic             visible_nx, dying_nx, dead_pulse_nx;
  logic [11:0]      step_x, step_y;
  logic             at_bound;

  // A re-head never keeps the current heading: a matching random pick rotates clockwise.
  assign new_dir = (lfsr[1:0] == direction) ? direction + 2'd1 : lfsr[1:0];

  // Candidate position one step ahead, widened so a step past a bound saturates cleanly.
  always_comb begin
    step_x   = {1'b0, topLeftX};
    step_y   = {1'b0, topLeftY};
    at_bound = 1'b0;
    unique case (direction)
      DIR_UP: begin
        if (step_y < 12'(Y_MIN) + 12'(SPEED)) step_y = 12'(Y_MIN);
        else                                  step_y = step_y - 12'(SPEED);
        at_bound = (step_y == 12'(Y_MIN));
      end
      DIR_RIGHT: begin
        step_x = step_x + 12'(SPEED);
        if (step_x > 12'(X_MAX)) step_x = 12'(X_MAX);
        at_bound = (step_x == 12'(X_MAX));
      end
      DIR_DOWN: begin
        step_y = step_y + 12'(SPEED);
        if (step_y > 12'(Y_MAX)) step_y = 12'(Y_MAX);
        at_bound = (step_y == 12'(Y_MAX));
      end
      DIR_LEFT: begin
        if (step_x < 12'(X_MIN) + 12'(SPEED)) step_x = 12'(X_MIN);
        else                                  step_x = step_x - 12'(SPEED);
        at_bound = (step_x == 12'(X_MIN));
      end
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_nx      = state;
    x_nx          = topLeftX;
    y_nx          = topLeftY;
    dir_nx        = direction;
    prev_x_nx     = prev_x;
    prev_y_nx     = prev_y;
    cnt_nx        = death_cnt;
    dead_pulse_nx = 1'b0;

    if (startOfFrame) begin
      unique case (state)
        IDLE: if (enable) state_nx = MOVE;
        MOVE: begin
          prev_x_nx = topLeftX;
          prev_y_nx = topLeftY;
          if (enable) begin
            if (expl_hit) begin
              state_nx = DYING;
              cnt_nx   = CNT_W'(DEATH_FRAMES);
            end else if (wall_hit || bomb_hit) begin
              x_nx   = prev_x;
              y_nx   = prev_y;
              dir_nx = new_dir;
            end else begin
              x_nx = step_x[10:0];
              y_nx = step_y[10:0];
              if (at_bound) dir_nx = new_dir;
            end
          end
        end
        DYING: begin
          if (death_cnt <= CNT_W'(1)) begin
            state_nx      = DEAD;
            cnt_nx        = '0;
            dead_pulse_nx = 1'b1;
          end else begin
            cnt_nx = death_cnt - CNT_W'(1);
          end
        end
        DEAD: ;
      endcase
    end

    visible_nx = (state_nx != DEAD);
    dying_nx   = (state_nx == DYING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      topLeftX   <= 11'(INITIAL_X);
      topLeftY   <= 11'(INITIAL_Y);
      prev_x     <= 11'(INITIAL_X);
      prev_y     <= 11'(INITIAL_Y);
      direction  <= DIR_RIGHT;
      death_cnt  <= '0;
      visible    <= 1'b1;
      dying      <= 1'b0;
      dead_pulse <= 1'b0;
      lfsr       <= LFSR_SEED;
      wall_hit   <= 1'b0;
      bomb_hit   <= 1'b0;
      expl_hit   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      state      <= state_nx;
      topLeftX   <= x_nx;
      topLeftY   <= y_nx;
      prev_x     <= prev_x_nx;
      prev_y     <= prev_y_nx;
      direction  <= dir_nx;
      death_cnt  <= cnt_nx;
      visible    <= visible_nx;
      dying      <= dying_nx;
      dead_pulse <= dead_pulse_nx;
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      // A pulse on the consuming edge is kept for the following frame.
      if (startOfFrame) begin
        wall_hit <= wall_collision;
        bomb_hit <= bomb_collision;
        expl_hit <= explosion_hit;
      end else begin
        wall_hit <= wall_hit | wall_collision;
        bomb_hit <= bomb_hit | bomb_collision;
        expl_hit <= expl_hit | explosion_hit;
      end
    end
  end

endmodule

// File: tb/tb_enemy_move.sv
// Self-checking bench for enemy_move: frame-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_enemy_move;

  localparam int         INITIAL_X    = 64;
  localparam int         INITIAL_Y    = 64;
  localparam int         SPEED        = 2;
  localparam int         X_MIN        = 32;
  localparam int         X_MAX        = 576;
  localparam int         Y_MIN        = 32;
  localparam int         Y_MAX        = 416;
  localparam int         DEATH_FRAMES = 30;
  localparam logic [7:0] LFSR_SEED    = 8'hA5;

  localparam int S_IDLE = 0, S_MOVE = 1, S_DYING = 2, S_DEAD = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        enable = 1'b0;
  logic        wall_collision = 1'b0;
  logic        bomb_collision = 1'b0;
  logic        explosion_hit = 1'b0;
  logic [10:0] topLeftX, topLeftY;
  logic [1:0]  direction;
  logic        visible, dying, dead_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  enemy_move #(
    .INITIAL_X(INITIAL_X), .INITIAL_Y(INITIAL_Y), .SPEED(SPEED),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .DEATH_FRAMES(DEATH_FRAMES), .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .wall_collision(wall_collision), .bomb_collision(bomb_collision),
    .explosion_hit(explosion_hit), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .direction(direction), .visible(visible), .dying(dying), .dead_pulse(dead_pulse)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // ---------------- behavioural model ----------------
  int         m_state, m_x, m_y, m_dir, m_px, m_py, m_cnt;
  bit         m_w, m_b, m_e, m_pulse;
  logic [7:0] m_lfsr;

  function automatic int pick(input int dir, input logic [7:0] l);
    int d;
    d = int'(l[1:0]);
    return (d == dir) ? (dir + 1) % 4 : d;
  endfunction

  task automatic model_step();
    int ox, oy, dx, dy, nx, ny;
    bit bound;
    if (reset) begin
      m_state = S_IDLE; m_x = INITIAL_X; m_y = INITIAL_Y; m_dir = 1;
      m_px = INITIAL_X; m_py = INITIAL_Y; m_cnt = 0;
      m_w = 0; m_b = 0; m_e = 0; m_pulse = 0; m_lfsr = LFSR_SEED;
      return;
    end
    m_pulse = 0;
    if (startOfFrame) begin
      case (m_state)
        S_IDLE: if (enable) m_state = S_MOVE;
        S_MOVE: begin
          ox = m_x; oy = m_y;
          if (enable) begin
            if (m_e) begin
              m_state = S_DYING;
              m_cnt   = DEATH_FRAMES;
            end else if (m_w || m_b) begin
              m_x = m_px; m_y = m_py;
              m_dir = pick(m_dir, m_lfsr);
            end else begin
              dx = (m_dir == 1) ? 1 : (m_dir == 3) ? -1 : 0;
              dy = (m_dir == 2) ? 1 : (m_dir == 0) ? -1 : 0;
              nx = m_x + dx * SPEED;
              ny = m_y + dy * SPEED;
              if (nx < X_MIN) nx = X_MIN;
              if (nx > X_MAX) nx = X_MAX;
              if (ny < Y_MIN) ny = Y_MIN;
              if (ny > Y_MAX) ny = Y_MAX;
              bound = (dx > 0 && nx == X_MAX) || (dx < 0 && nx == X_MIN) ||
                      (dy > 0 && ny == Y_MAX) || (dy < 0 && ny == Y_MIN);
              m_x = nx; m_y = ny;
              if (bound) m_dir = pick(m_dir, m_lfsr);
            end
          end
          m_px = ox; m_py = oy;
        end
        S_DYING: begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_state = S_DEAD;
            m_pulse = 1;
          end
        end
        default: ;
      endcase
      m_w = wall_collision; m_b = bomb_collision; m_e = explosion_hit;
    end else begin
      m_w = m_w | wall_collision; m_b = m_b | bomb_collision; m_e = m_e | explosion_hit;
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("model_x",          topLeftX,   m_x);
      check("model_y",          topLeftY,   m_y);
      check("model_dir",        direction,  m_dir);
      check("model_visible",    visible,    int'(m_state != S_DEAD));
      check("model_dying",      dying,      int'(m_state == S_DYING));
      check("model_dead_pulse", dead_pulse, int'(m_pulse));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got 1, expected 0");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sof_tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof_tick();
      idle(3);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int gap;

    // Reset state
    tick();
    check("reset_x", topLeftX, 64);
    check("reset_y", topLeftY, 64);
    check("reset_dir", direction, 1);
    check("reset_visible", visible, 1);
    check("reset_dying", dying, 0);
    check("reset_dead_pulse", dead_pulse, 0);
    reset = 1'b0;

    // Free run: first frame leaves IDLE, nine steps follow
    enable = 1'b1;
    frames(10);
    check("free_x", topLeftX, 82);
    check("free_y", topLeftY, 64);
    check("free_dir", direction, 1);

    // Wall back-off to the previous-frame position
    wall_collision = 1'b1;
    tick();
    wall_collision = 1'b0;
    idle(1);
    sof_tick();
    check("wall_x", topLeftX, 80);
    check("wall_dir_changed", int'(direction != 2'd1), 1);
    idle(3);

    // Bound: 256 steps from 64 reach X_MAX exactly and force a new heading
    do_reset();
    frames(257);
    check("bound_x", topLeftX, 576);
    check("bound_y", topLeftY, 64);
    check("bound_dir_changed", int'(direction != 2'd1), 1);

    // Death: explosion beats wall in the same frame
    explosion_hit = 1'b1;
    wall_collision = 1'b1;
    tick();
    explosion_hit = 1'b0;
    wall_collision = 1'b0;
    sof_tick();
    check("death_dying", dying, 1);
    check("death_x_held", topLeftX, 576);
    check("death_visible", visible, 1);
    for (int i = 1; i < DEATH_FRAMES; i++) begin
      idle(3);
      sof_tick();
    end
    check("death_still_dying", dying, 1);
    check("death_no_early_pulse", dead_pulse, 0);
    idle(3);
    sof_tick();
    check("dead_pulse_high", dead_pulse, 1);
    check("dead_visible", visible, 0);
    check("dead_dying", dying, 0);
    tick();
    check("dead_pulse_single", dead_pulse, 0);
    frames(2);
    check("dead_stays_hidden", visible, 0);

    // Freeze with enable low
    do_reset();
    frames(3);
    check("pre_freeze_x", topLeftX, 68);
    enable = 1'b0;
    frames(5);
    check("freeze_x", topLeftX, 68);
    check("freeze_y", topLeftY, 64);

    // Reset during DYING
    enable = 1'b1;
    explosion_hit = 1'b1;
    tick();
    explosion_hit = 1'b0;
    sof_tick();
    check("pre_reset_dying", dying, 1);
    idle(2);
    do_reset();
    check("rst_dying_x", topLeftX, 64);
    check("rst_dying_y", topLeftY, 64);
    check("rst_dying_visible", visible, 1);
    check("rst_dying_dying", dying, 0);
    check("rst_dying_dir", direction, 1);

    // Randomized run against the model
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      if (gap == 0) begin
        startOfFrame = 1'b1;
        gap = int'($urandom_range(2, 6));
        enable = ($urandom_range(0, 9) != 0);
      end else begin
        startOfFrame = 1'b0;
        gap--;
      end
      wall_collision = ($urandom_range(0, 29) == 0);
      bomb_collision = ($urandom_range(0, 49) == 0);
      explosion_hit  = ($urandom_range(0, 399) == 0);
      reset          = ($urandom_range(0, 499) == 0);
      tick();
    end
    startOfFrame = 1'b0;
    wall_collision = 1'b0;
    bomb_collision = 1'b0;
    explosion_hit = 1'b0;
    reset = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
